// File: rtl/clk2_word_sink_if.sv
// Handshake bundle for clk2_word_sink: upstream word strobe/backpressure and downstream byte stream.
// master = the side that produces words and consumes bytes; slave = the sink itself.
interface clk2_word_sink_if;
  logic        dvalid;
  logic [31:0] din_word;
  logic        dbusy;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;

  modport master (
    output dvalid, din_word, out_ready,
    input  dbusy, out_valid, out_data, out_last
  );

  modport slave (
    input  dvalid, din_word, out_ready,
    output dbusy, out_valid, out_data, out_last
  );
endinterface

// File: rtl/clk2_word_sink.sv
// Destination-side word FIFO plus MSB-first byte serializer with sticky overflow.
// Define SINK_CHECKSUM_EN to append an XOR checksum byte to every frame.
module clk2_word_sink #(
  parameter int DEPTH = 4
) (
  input  logic              dclk,
  input  logic              rst_n,
  clk2_word_sink_if.slave   bus,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef SINK_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [23:0]   sreg;
  logic [2:0]    byte_idx;
  logic          full, push, pop, accept;
`ifdef SINK_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    full      = (count == CW'(DEPTH));
    pop       = (state == LOAD) && (count != '0);
    push      = bus.dvalid && (!full || pop);
    accept    = (state == SEND) && bus.out_valid && bus.out_ready;
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (pop && !push) count_nxt = count - CW'(1);
  end

  // NOTE: the word storage has no reset; count and pointers alone decide what is valid.
  always_ff @(posedge dclk) begin
    if (push) mem[wr_ptr] <= bus.din_word;
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      bus.dbusy <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      // Two words of slack cover strobes already in flight upstream.
      bus.dbusy <= (count_nxt >= CW'(DEPTH - 2));
      if (bus.dvalid && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sreg          <= '0;
      byte_idx      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
`ifdef SINK_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Looking at the post-push count lets a fresh word reach SEND two cycles after its strobe.
          if (count_nxt != '0) state <= LOAD;
        end
        LOAD: begin
          sreg          <= mem[rd_ptr][23:0];
          bus.out_data  <= mem[rd_ptr][31:24];
          bus.out_last  <= 1'b0;
          bus.out_valid <= 1'b1;
          byte_idx      <= '0;
`ifdef SINK_CHECKSUM_EN
          csum <= mem[rd_ptr][31:24] ^ mem[rd_ptr][23:16] ^ mem[rd_ptr][15:8] ^ mem[rd_ptr][7:0];
`endif
          state <= SEND;
        end
        SEND: begin
          if (accept) begin
            if (byte_idx == LAST_IDX) begin
              bus.out_valid <= 1'b0;
              bus.out_data  <= '0;
              bus.out_last  <= 1'b0;
              state         <= (count_nxt != '0) ? LOAD : IDLE;
            end else begin
              byte_idx     <= byte_idx + 3'd1;
              sreg         <= {sreg[15:0], 8'h00};
              bus.out_last <= ((byte_idx + 3'd1) == LAST_IDX);
`ifdef SINK_CHECKSUM_EN
              bus.out_data <= (byte_idx == 3'd3) ? csum : sreg[23:16];
`else
              bus.out_data <= sreg[23:16];
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk2_word_sink.sv
// Directed bench for clk2_word_sink: latency, framing, throughput, backpressure/overflow, stalls, reset.
// Expected bytes come from the bench's own byte/checksum function.
module tb_clk2_word_sink;

  localparam int DEPTH = 4;
`ifdef SINK_CHECKSUM_EN
  localparam int NBYTES = 5;
`else
  localparam int NBYTES = 4;
`endif

  logic dclk = 1'b0;
  logic rst_n = 1'b0;
  logic overflow;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  clk2_word_sink_if bus ();

  clk2_word_sink #(.DEPTH(DEPTH)) dut (
    .dclk     (dclk),
    .rst_n    (rst_n),
    .bus      (bus),
    .overflow (overflow)
  );

  always #5 dclk = ~dclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i);
    case (i)
      0:       return w[31:24];
      1:       return w[23:16];
      2:       return w[15:8];
      3:       return w[7:0];
      default: return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endcase
  endfunction

  task automatic tick();
    @(posedge dclk);
    @(negedge dclk);
    cyc++;
  endtask

  task automatic push(input logic [31:0] w);
    bus.dvalid   = 1'b1;
    bus.din_word = w;
    tick();
    bus.dvalid   = 1'b0;
  endtask

  // Receives one frame with out_ready held high; returns the cycle its first byte appeared.
  task automatic recv_frame(input string tag, input logic [31:0] w, output int first_cyc);
    int waited = 0;
    first_cyc = -1;
    bus.out_ready = 1'b1;
    while (bus.out_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (bus.out_valid !== 1'b1) begin
      check({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
      return;
    end
    first_cyc = cyc;
    for (int i = 0; i < NBYTES; i++) begin
      check($sformatf("%s_b%0d", tag, i), 32'(bus.out_data), 32'(exp_byte(w, i)));
      check($sformatf("%s_last%0d", tag, i), 32'(bus.out_last), 32'(i == NBYTES - 1));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words [6];
    logic [31:0] rw [3];
    logic        pat [8];
    int f0, f1, idx, seen;

    bus.dvalid    = 1'b0;
    bus.din_word  = '0;
    bus.out_ready = 1'b0;

    // Reset values
    #12;
    check("rst_dbusy",     32'(bus.dbusy),     32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_overflow",  32'(overflow),      32'd0);
    @(negedge dclk);
    rst_n = 1'b1;
    tick();

    // Single word: byte0 appears two cycles after the strobe cycle
    bus.out_ready = 1'b1;
    push(32'h1234_5678);
    check("lat_t1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("lat_t2_valid", 32'(bus.out_valid), 32'd1);
    recv_frame("w1234", 32'h1234_5678, f0);
    check("w1234_done", 32'(bus.out_valid), 32'd0);

    // Checksum-rich pattern
    push(32'hA5A5_FF00);
    recv_frame("wa5a5", 32'hA5A5_FF00, f0);
    check("wa5a5_done", 32'(bus.out_valid), 32'd0);

    // Back-to-back frames: one frame per NBYTES+1 cycles
    push(32'hDEAD_BEEF);
    push(32'h0102_0304);
    recv_frame("tp0", 32'hDEAD_BEEF, f0);
    recv_frame("tp1", 32'h0102_0304, f1);
    check("tp_period", 32'(f1 - f0), 32'(NBYTES + 1));
    tick();

    // Backpressure/overflow: first word sits in the serializer, DEPTH more fill the FIFO, the next drops
    bus.out_ready = 1'b0;
    words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
              32'h4444_4444, 32'h5555_5555, 32'h6666_6666};
    for (int k = 0; k < 6; k++) begin
      push(words[k]);
      check($sformatf("bp_dbusy%0d", k), 32'(bus.dbusy),  32'(k >= 2));
      check($sformatf("bp_ovf%0d", k),   32'(overflow),   32'(k == 5));
    end
    check("bp_hold_data", 32'(bus.out_data), 32'h11);
    for (int k = 0; k < 5; k++) recv_frame($sformatf("bp_f%0d", k), words[k], f0);
    tick();
    check("bp_drained_valid", 32'(bus.out_valid), 32'd0);
    check("bp_drained_dbusy", 32'(bus.dbusy),     32'd0);
    check("bp_ovf_sticky",    32'(overflow),      32'd1);

    // Stall mid-frame: data/last must hold while out_ready is low
    bus.out_ready = 1'b0;
    push(32'hC3D2_E1F0);
    tick();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    idx = 0;
    for (int j = 0; j < 8 && idx < NBYTES; j++) begin
      check($sformatf("st_data%0d", j), 32'(bus.out_data), 32'(exp_byte(32'hC3D2_E1F0, idx)));
      check($sformatf("st_last%0d", j), 32'(bus.out_last), 32'(idx == NBYTES - 1));
      bus.out_ready = pat[j];
      tick();
      if (pat[j]) idx++;
    end
    check("st_count", 32'(idx), 32'(NBYTES));
    check("st_done",  32'(bus.out_valid), 32'd0);

    // Reset during byte1 with two words queued behind the active frame
    bus.out_ready = 1'b0;
    rw = '{32'hAABB_CCDD, 32'h1357_9BDF, 32'h2468_ACE0};
    for (int k = 0; k < 3; k++) push(rw[k]);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("mr_byte1", 32'(bus.out_data), 32'hBB);
    #2 rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(bus.out_valid), 32'd0);
    check("mr_data",  32'(bus.out_data),  32'd0);
    check("mr_last",  32'(bus.out_last),  32'd0);
    check("mr_dbusy", 32'(bus.dbusy),     32'd0);
    check("mr_ovf",   32'(overflow),      32'd0);
    @(negedge dclk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.out_valid !== 1'b0) seen++;
    end
    check("mr_silent", 32'(seen), 32'd0);
    push(32'h0F1E_2D3C);
    recv_frame("mr_new", 32'h0F1E_2D3C, f0);
    check("mr_new_done", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
